// File: rtl/ev_operand_arbiter.sv
// Round-robin arbiter sharing the exe_env u32 word store port among NUM_REQ operation units.
// Immediate operands are answered locally; address operands go through one store access.
module ev_operand_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_BITS = 6
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0]                 req_write,
  input  logic [NUM_REQ*(ADDR_BITS+1)-1:0]   req_operand,
  input  logic [NUM_REQ*32-1:0]              req_wdata,
  output logic [NUM_REQ-1:0]                 resp_valid,
  output logic [31:0]                        resp_data,
  output logic                               resp_err,
  output logic                               busy,
  output logic                               mem_rd_en,
  output logic                               mem_wr_en,
  output logic [ADDR_BITS-1:0]               mem_addr,
  output logic [31:0]                        mem_wdata,
  input  logic [31:0]                        mem_rdata
);

  localparam int OP_W  = ADDR_BITS + 1;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_next;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   win_q;
  logic               write_q;
  logic [OP_W-1:0]    operand_q;
  logic [31:0]        wdata_q;

  logic               grant_found;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W:0]     cand;
  logic               accept;

  logic               imm_q;
  logic [ADDR_BITS-1:0] value_q;

  assign imm_q   = operand_q[OP_W-1];
  assign value_q = operand_q[ADDR_BITS-1:0];

  // Search starts just after the last winner and wraps, so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[cand[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
  end

  assign accept = (state_q == IDLE) && grant_found && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= PTR_W'(NUM_REQ - 1);
      win_q     <= '0;
      write_q   <= 1'b0;
      operand_q <= '0;
      wdata_q   <= '0;
    end else if (accept) begin
      ptr_q     <= grant_idx;
      win_q     <= grant_idx;
      write_q   <= req_write[grant_idx];
      operand_q <= req_operand[grant_idx*OP_W +: OP_W];
      wdata_q   <= req_wdata[grant_idx*32 +: 32];
    end
  end

  // Store and response outputs come only from latched state; req_ready is the sole
  // combinational function of the request inputs.
  always_comb begin
    state_next = state_q;
    req_ready  = '0;
    resp_valid = '0;
    resp_data  = '0;
    resp_err   = 1'b0;
    busy       = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_ready[grant_idx] = 1'b1;
          state_next           = ISSUE;
        end
      end
      ISSUE: begin
        busy = 1'b1;
        if (!imm_q) begin
          mem_addr = value_q;
          if (write_q) begin
            mem_wr_en = 1'b1;
            mem_wdata = wdata_q;
          end else begin
            mem_rd_en = 1'b1;
          end
        end
        state_next = RESP;
      end
      RESP: begin
        busy              = 1'b1;
        resp_valid[win_q] = 1'b1;
        if (write_q) begin
          resp_err = imm_q;
        end else if (imm_q) begin
          resp_data = {{(32-ADDR_BITS){value_q[ADDR_BITS-1]}}, value_q};
        end else begin
          resp_data = mem_rdata;
        end
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/ev_operand_arbiter.md
Name: ev_operand_arbiter

Overview:
Shares the single read/write port of the execution-environment u32 word store (exe_env_u viewed as u32 words) among NUM_REQ operation units.
Each unit presents an ia_u32 operand, either an immediate or an address, plus a read/write flag.
The arbiter grants requesters round-robin and sequences the memory access. For address operands it returns the word read; for immediate operands it returns the sign-extended immediate without touching memory.
It sits between the operation units and the exe_env storage.

Parameters:
NUM_REQ, 4, number of requesting operation units (2..8)
ADDR_BITS, 6, width of the ia_u32 value field, equal to address_u32_bits; the operand is ADDR_BITS+1 bits wide

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  bit i: requester i has a pending request
req_ready  out  NUM_REQ  bit i: request i accepted this cycle (one-hot or zero)
req_write  in  NUM_REQ  bit i: 1 = write, 0 = read
req_operand  in  NUM_REQ*(ADDR_BITS+1)  slice i = {immediate, value} (ia_u32_t layout, immediate is the MSB)
req_wdata  in  NUM_REQ*32  slice i = write data
resp_valid  out  NUM_REQ  one-cycle pulse to the requester being answered
resp_data  out  32  shared response data, qualified by resp_valid
resp_err  out  1  qualified by resp_valid; 1 = illegal request
busy  out  1  high in any state other than IDLE
mem_rd_en  out  1  store read strobe
mem_wr_en  out  1  store write strobe
mem_addr  out  ADDR_BITS  store word address
mem_wdata  out  32  store write data
mem_rdata  in  32  store read data, valid the cycle after mem_rd_en

Behaviour:
- State machine: IDLE -> ISSUE -> RESP -> IDLE. Reset forces IDLE.
- All outputs are 0 in reset and in IDLE, except req_ready as defined below.
- IDLE:
  - If any req_valid is high, select winner w by round-robin, searching from (ptr+1) mod NUM_REQ upward with wrap.
  - Assert req_ready[w] combinationally in this cycle.
  - Latch w, write flag, operand and wdata; set ptr<=w; go to ISSUE.
  - If no req_valid is high, stay in IDLE.
  - ptr resets to NUM_REQ-1, so requester 0 wins first.
- ISSUE, one cycle:
  - Address read: mem_rd_en=1, mem_addr=value.
  - Address write: mem_wr_en=1, mem_addr=value, mem_wdata=latched wdata.
  - Immediate read or immediate write: no strobe.
  - Always go to RESP.
- RESP, one cycle:
  - resp_valid[w]=1.
  - resp_data:
    - Address read: mem_rdata.
    - Immediate read: value sign-extended from ADDR_BITS to 32 (two's complement; MSB of value is the sign).
    - Any write: 0.
  - resp_err=1 only for an immediate write.
  - Go to IDLE.
- mem_* and resp_* outputs decode from registered state only; no combinational path from req_* to them. Only req_ready depends combinationally on req_valid.
- Latency and throughput: accept at cycle T, memory strobe at T+1, response at T+2. A new grant is possible at T+3, so the maximum rate is one request per 3 cycles.
- Requesters hold req_valid, req_write, req_operand and req_wdata stable until req_ready. After acceptance they may change freely; latched copies are used.
- A requester whose req_valid drops before it is granted is simply skipped; no state is kept for it.
- A new request from the requester currently in service is not accepted until the FSM returns to IDLE.
- Reset mid-operation, in ISSUE or RESP:
  - Next cycle is IDLE with all outputs 0.
  - The in-flight response is dropped, and no resp_valid is issued for it.
  - A write strobe already issued is not undone.
- Fairness: with all requesters continuously valid, every requester is granted once per NUM_REQ grants.

Test Plan:
1. Reset, then req_valid[0]=1, operand {1,6'b000101}, read -> req_ready[0] at T; no mem strobe at T+1; resp_valid[0] at T+2 with resp_data=0x00000005, resp_err=0.
2. Immediate read {1,6'b111111} -> resp_data=0xFFFFFFFF. Immediate read {1,6'b100000} -> resp_data=0xFFFFFFE0.
3. req2 address write {0,6'd3}, wdata=0x12345678 -> mem_wr_en=1, mem_addr=3, mem_wdata=0x12345678 at T+1; resp_valid[2] at T+2 with resp_data=0. Then req2 address read of addr 3 -> mem_rd_en=1, mem_addr=3 at T+1; resp_data=0x12345678 at T+2.
4. All four req_valid held high from reset -> grant order 0,1,2,3,0,1; grants 3 cycles apart; busy low only in the grant cycles.
5. req1 immediate write {1,6'd7} -> no mem_wr_en; resp_valid[1] with resp_err=1, resp_data=0.
6. reset asserted in the ISSUE cycle of an address read -> no resp_valid; next cycle IDLE with all outputs 0; ptr=NUM_REQ-1, so a simultaneous request from 0 and 3 grants 0.
